// File: rtl/isa_pkg.sv
// Opcode map, bubble/INT encodings, sequencer state type and decode classification
// helpers shared by the interrupt sequencer.
package isa_pkg;

    localparam logic [4:0] OP_JMP  = 5'b10100;
    localparam logic [4:0] OP_JC   = 5'b10101;
    localparam logic [4:0] OP_JN   = 5'b10110;
    localparam logic [4:0] OP_JZ   = 5'b10111;
    localparam logic [4:0] OP_LDM  = 5'b11000;
    localparam logic [4:0] OP_CALL = 5'b11001;
    localparam logic [4:0] OP_STM  = 5'b11010;
    localparam logic [4:0] OP_RET  = 5'b11011;

    localparam logic [2:0]  FN_TWO_WORD   = 3'b100;
    localparam logic [15:0] DEF_NOP_WORD  = 16'h07F8;
    localparam logic [15:0] DEF_INT_WORD0 = 16'hF480;
    localparam logic [15:0] DEF_INT_WORD1 = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS,
        S_DRAIN2,
        S_DRAIN1,
        S_INJ0,
        S_INJ1,
        S_REDIRECT,
        S_WAIT_RTI
    } state_e;

    // Control ops whose second half is still in flight behind decode need two bubbles.
    function automatic logic is_ctrl_second(input logic [4:0] opcode);
        return opcode inside {OP_CALL, OP_RET, OP_JZ, OP_JN, OP_JC, OP_JMP};
    endfunction

    function automatic logic is_two_word(input logic [4:0] opcode, input logic [2:0] funct);
        return (funct == FN_TWO_WORD) || (opcode inside {OP_LDM, OP_STM});
    endfunction

    function automatic state_e classify(input logic [4:0] opcode, input logic [2:0] funct,
                                        input logic is_jmp);
        if (is_ctrl_second(opcode))
            return S_DRAIN2;
        else if (is_two_word(opcode, funct))
            return S_PASS;
        else if (is_jmp)
            return S_DRAIN1;
        else
            return S_INJ0;
    endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Lowest-index-wins priority encoder over the enabled pending requests.
module irq_priority_enc #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [SRC_W-1:0]   sel,
    output logic               any
);

    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) sel = SRC_W'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/interrupt_sequencer.sv
// Multi-source interrupt sequencer: edge-latched requests, decode drain, two-word INT
// injection and an IVT fetch redirect, with optional hold-off until RTI retires.
module interrupt_sequencer
    import isa_pkg::*;
#(
    parameter int                 NUM_SRC   = 4,
    parameter int                 SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter int                 INSTR_W   = 16,
    parameter bit                 NESTING   = 1'b0,
    parameter logic [INSTR_W-1:0] INT_WORD0 = DEF_INT_WORD0,
    parameter logic [INSTR_W-1:0] INT_WORD1 = DEF_INT_WORD1,
    parameter logic [INSTR_W-1:0] NOP_WORD  = DEF_NOP_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               glb_en,
    input  logic [4:0]         dec_opcode,
    input  logic [2:0]         dec_funct,
    input  logic               dec_is_jmp,
    input  logic               rti_done,
    output logic               int_stall,
    output logic               int_inject,
    output logic [INSTR_W-1:0] int_instr,
    output logic               bubble_self,
    output logic               bubble_fwd,
    output logic               int_redirect,
    output logic [SRC_W-1:0]   int_vector,
    output logic               int_active
);

    state_e               state_q, state_d;
    logic [SRC_W-1:0]     vec_q, vec_d;
    logic [NUM_SRC-1:0]   pend_q, pend_d, irq_q, clr;
    logic [SRC_W-1:0]     sel;
    logic                 any, req;

    logic                 stall_d, inject_d, bself_d, bfwd_d, redir_d, active_d;
    logic [INSTR_W-1:0]   instr_d;
    logic [SRC_W-1:0]     vector_d;

    irq_priority_enc #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_enc (
        .req (pend_q & irq_mask),
        .sel (sel),
        .any (any)
    );

    assign req    = any & glb_en;
    assign clr    = (state_q == S_INJ0) ? (NUM_SRC'(1) << vec_q) : '0;
    // New edges win over the INJ0 clear of the same source.
    assign pend_d = (pend_q & ~clr) | (irq & ~irq_q);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    vec_d   = sel;
                    state_d = classify(dec_opcode, dec_funct, dec_is_jmp);
                end
            end
            S_PASS:     state_d = classify(dec_opcode, dec_funct, dec_is_jmp);
            S_DRAIN2:   state_d = S_DRAIN1;
            S_DRAIN1:   state_d = S_INJ0;
            S_INJ0:     state_d = S_INJ1;
            S_INJ1:     state_d = S_REDIRECT;
            S_REDIRECT: state_d = NESTING ? S_IDLE : S_WAIT_RTI;
            S_WAIT_RTI: if (rti_done) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Outputs are decoded from the state being entered so they register with it.
        stall_d  = 1'b0;
        inject_d = 1'b0;
        instr_d  = '0;
        bself_d  = 1'b0;
        bfwd_d   = 1'b0;
        redir_d  = 1'b0;
        vector_d = '0;
        active_d = (state_d != S_IDLE);
        case (state_d)
            S_DRAIN2, S_DRAIN1: begin
                stall_d  = 1'b1;
                inject_d = 1'b1;
                bself_d  = 1'b1;
                bfwd_d   = 1'b1;
                instr_d  = NOP_WORD;
            end
            S_INJ0: begin
                stall_d  = 1'b1;
                inject_d = 1'b1;
                instr_d  = INT_WORD0;
            end
            S_INJ1: begin
                stall_d  = 1'b1;
                inject_d = 1'b1;
                instr_d  = {INT_WORD1[INSTR_W-1:SRC_W], vec_d};
                vector_d = vec_d;
            end
            S_REDIRECT: begin
                redir_d  = 1'b1;
                vector_d = vec_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // History follows the line even in reset, so a level held across reset is not an edge.
        irq_q <= irq;
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            pend_q       <= '0;
            int_stall    <= 1'b0;
            int_inject   <= 1'b0;
            int_instr    <= '0;
            bubble_self  <= 1'b0;
            bubble_fwd   <= 1'b0;
            int_redirect <= 1'b0;
            int_vector   <= '0;
            int_active   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            pend_q       <= pend_d;
            int_stall    <= stall_d;
            int_inject   <= inject_d;
            int_instr    <= instr_d;
            bubble_self  <= bself_d;
            bubble_fwd   <= bfwd_d;
            int_redirect <= redir_d;
            int_vector   <= vector_d;
            int_active   <= active_d;
        end
    end

endmodule
